// File: rtl/sipo_tge.sv
// rtl/sipo_tge.sv - serial-in parallel-out assembler with double-buffered FIFO hand-off
//
// Purpose: collects LANES = OUTPUT_SIZE/INPUT_SIZE serial words into one wide
// word (first word in the LSBs), then presents it to a downstream FIFO from a
// separate output register, so assembly of the next group continues while the
// previous word waits for FIFO space.
//
// Optional feature: define SIPO_TGE_SOF_EN to add the i_sof start-of-frame
// input, which forces the accompanying word into lane 0.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   ce         in   clock enable; low holds every register and blocks fifo_we
//   i_serial   in   [INPUT_SIZE-1:0] serial data word
//   valid      in   i_serial qualifier
//   i_sof      in   (SIPO_TGE_SOF_EN only) word starts a new group
//   fifo_full  in   downstream FIFO full
//   o_parallel out  [OUTPUT_SIZE-1:0] assembled word presented to the FIFO
//   fifo_we    out  FIFO write enable (combinational)
//   overflow   out  sticky: a completed or partial group was dropped
//   drop_cnt   out  [15:0] dropped group count, saturating

module sipo_tge #(
    parameter int INPUT_SIZE  = 64,
    parameter int OUTPUT_SIZE = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [INPUT_SIZE-1:0]  i_serial,
    input  logic                   valid,
`ifdef SIPO_TGE_SOF_EN
    input  logic                   i_sof,
`endif
    input  logic                   fifo_full,
    output logic [OUTPUT_SIZE-1:0] o_parallel,
    output logic                   fifo_we,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
);

    localparam int             LANES = OUTPUT_SIZE / INPUT_SIZE;
    localparam int             LW    = $clog2(LANES);
    localparam logic [LW-1:0]  LAST  = LW'(LANES - 1);

    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [OUTPUT_SIZE-1:0] asm_q, asm_d;
    logic [OUTPUT_SIZE-1:0] out_q, out_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic                   accept;
    logic                   sof;
    logic                   complete;
    logic                   drop;
    logic [LW-1:0]          wr_lane;
    logic [OUTPUT_SIZE-1:0] asm_full;

`ifdef SIPO_TGE_SOF_EN
    assign sof = ce & valid & i_sof;
`else
    assign sof = 1'b0;
`endif

    always_comb begin
        accept  = ce & valid;
        wr_lane = sof ? '0 : lane_q;

        // Assembly contents including the word arriving this cycle, so a
        // completing group can be moved to the output register in one edge.
        asm_full = asm_q;
        for (int k = 0; k < LANES; k++) begin
            if (accept && (wr_lane == LW'(k))) begin
                asm_full[k*INPUT_SIZE +: INPUT_SIZE] = i_serial;
            end
        end

        fifo_we  = (state_q == PENDING) & ~fifo_full & ce;
        complete = accept & ~sof & (lane_q == LAST);

        // A new group is lost either when it completes behind a word that is
        // not leaving this edge, or when start-of-frame cuts a partial group.
        drop = (complete & (state_q == PENDING) & ~fifo_we)
             | (sof & (lane_q != '0));

        state_d    = state_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        out_d      = out_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (accept) begin
            asm_d  = asm_full;
            // LANES is a power of two, so the increment wraps LAST -> 0.
            lane_d = sof ? LW'(1) : lane_q + LW'(1);
        end

        if (complete && ((state_q == EMPTY) || fifo_we)) begin
            out_d   = asm_full;
            state_d = PENDING;
        end else if (fifo_we) begin
            state_d = EMPTY;
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            lane_q     <= '0;
            asm_q      <= '0;
            out_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_parallel = out_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_sipo_tge.sv
// tb/tb_sipo_tge.sv - scoreboard bench for sipo_tge (8-bit words, 16 lanes)

module tb_sipo_tge;

    localparam int IW = 8;
    localparam int OW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1;
    logic [IW-1:0] i_serial = '0;
    logic          valid = 1'b0;
    logic          i_sof = 1'b0;
    logic          fifo_full = 1'b0;
    logic [OW-1:0] o_parallel;
    logic          fifo_we;
    logic          overflow;
    logic [15:0]   drop_cnt;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int base_wr;
    logic [OW-1:0] sb[$];

    sipo_tge #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW)) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .i_serial(i_serial),
        .valid(valid),
`ifdef SIPO_TGE_SOF_EN
        .i_sof(i_sof),
`endif
        .fifo_full(fifo_full),
        .o_parallel(o_parallel),
        .fifo_we(fifo_we),
        .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] grp(input logic [IW-1:0] base);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < OW / IW; k++) r[k*IW +: IW] = base + IW'(k);
        return r;
    endfunction

    // A write completes at the next rising edge whenever fifo_we is high here.
    always @(negedge clk) begin
        if (fifo_we === 1'b1) begin
            wr_cnt++;
            if (sb.size() == 0) check("unexpected_write", o_parallel, '1);
            else check("write_data", o_parallel, sb.pop_front());
        end
    end

    task automatic cyc(input logic v, input logic [IW-1:0] d);
        valid    = v;
        i_serial = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0);
    endtask

    task automatic send_grp(input logic [IW-1:0] base, input int cnt, input bit gaps);
        for (int k = 0; k < cnt; k++) begin
            cyc(1'b1, base + IW'(k));
            if (gaps) cyc(1'b0, 8'hEE);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        idle(2);
        rst = 1'b0;
        check("rst_o_parallel", o_parallel, '0);
        check("rst_fifo_we", OW'(fifo_we), 0);
        check("rst_overflow", OW'(overflow), 0);
        check("rst_drop_cnt", OW'(drop_cnt), 0);

        // 16 consecutive words, write one cycle after the last word;
        // a ce-low cycle must hold the pending word and block the write
        base_wr = wr_cnt;
        sb.push_back(grp(8'h00));
        send_grp(8'h00, 16, 1'b0);
        check("t1_we_latency", OW'(fifo_we), 1);
        ce = 1'b0;
        #1;
        check("t1_ce_blocks_we", OW'(fifo_we), 0);
        valid = 1'b1;
        i_serial = 8'hDD;
        @(posedge clk);
        #1;
        valid = 1'b0;
        ce = 1'b1;
        idle(3);
        check("t1_writes", OW'(wr_cnt - base_wr), 1);

        // valid toggling: gaps do not disturb alignment
        base_wr = wr_cnt;
        sb.push_back(grp(8'h00));
        send_grp(8'h00, 16, 1'b1);
        idle(2);
        check("t2_writes", OW'(wr_cnt - base_wr), 1);

        // fifo_full for 40 clocks across 32 words: first group held, second dropped
        base_wr = wr_cnt;
        sb.push_back(grp(8'h20));
        fifo_full = 1'b1;
        send_grp(8'h20, 16, 1'b0);
        send_grp(8'h40, 16, 1'b0);
        idle(8);
        check("t3_no_write_while_full", OW'(wr_cnt - base_wr), 0);
        check("t3_held_word", o_parallel, grp(8'h20));
        check("t3_overflow", OW'(overflow), 1);
        check("t3_drop_cnt", OW'(drop_cnt), 1);
        fifo_full = 1'b0;
        idle(3);
        check("t3_writes", OW'(wr_cnt - base_wr), 1);
        check("t3_overflow_sticky", OW'(overflow), 1);

        // 64 continuous words: four writes, no drops
        do_reset();
        base_wr = wr_cnt;
        for (int g = 0; g < 4; g++) sb.push_back(grp(IW'(g * 16)));
        send_grp(8'h00, 64, 1'b0);
        idle(3);
        check("t4_writes", OW'(wr_cnt - base_wr), 4);
        check("t4_drop_cnt", OW'(drop_cnt), 0);

        // group completes on the very edge the previous word is written
        base_wr = wr_cnt;
        sb.push_back(grp(8'h50));
        sb.push_back(grp(8'h60));
        fifo_full = 1'b1;
        send_grp(8'h50, 16, 1'b0);
        send_grp(8'h60, 15, 1'b0);
        fifo_full = 1'b0;
        cyc(1'b1, 8'h6F);
        idle(3);
        check("t5_writes", OW'(wr_cnt - base_wr), 2);
        check("t5_drop_cnt", OW'(drop_cnt), 0);
        check("t5_overflow", OW'(overflow), 0);

        // reset while PENDING and mid-group (with ce low): nothing written
        base_wr = wr_cnt;
        fifo_full = 1'b1;
        send_grp(8'h70, 16, 1'b0);
        send_grp(8'h80, 7, 1'b0);
        rst = 1'b1;
        ce = 1'b0;
        idle(1);
        rst = 1'b0;
        ce = 1'b1;
        fifo_full = 1'b0;
        #1;
        check("t6_rst_o_parallel", o_parallel, '0);
        check("t6_rst_fifo_we", OW'(fifo_we), 0);
        sb.push_back(grp(8'h10));
        send_grp(8'h10, 16, 1'b0);
        idle(3);
        check("t6_writes", OW'(wr_cnt - base_wr), 1);

`ifdef SIPO_TGE_SOF_EN
        // start-of-frame on word 5 of a group realigns and counts a drop
        do_reset();
        base_wr = wr_cnt;
        send_grp(8'hA0, 4, 1'b0);
        i_sof = 1'b1;
        cyc(1'b1, 8'hB0);
        i_sof = 1'b0;
        check("sof_drop_cnt", OW'(drop_cnt), 1);
        check("sof_overflow", OW'(overflow), 1);
        sb.push_back(grp(8'hB0));
        send_grp(8'hB1, 15, 1'b0);
        idle(3);
        check("sof_writes", OW'(wr_cnt - base_wr), 1);
`endif

        check("sb_empty", OW'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
